// File: rtl/mat_dma_pkg.sv
// -----------------------------------------------------------------------------
// mat_dma_pkg
// Shared types and sizing helpers for the ROM-to-matrix loader slice.
//   mat_dma_state_t : loader FSM states
//   clog2_min1      : address width that never collapses to zero bits
//   mat_n           : element count of a ROWS x COLS matrix
//   mat_ram_aw      : staging RAM address width
//   mat_csum_w      : checksum width (element width plus carry headroom)
// -----------------------------------------------------------------------------
package mat_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_COPY = 3'd1,
      ST_WAIT = 3'd2,
      ST_READ = 3'd3,
      ST_LAST = 3'd4,
      ST_DONE = 3'd5
   } mat_dma_state_t;

   function automatic int clog2_min1(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

   function automatic int mat_n(input int rows, input int cols);
      return rows * cols;
   endfunction

   function automatic int mat_ram_aw(input int rows, input int cols);
      return clog2_min1(rows * cols);
   endfunction

   function automatic int mat_csum_w(input int data_width, input int rows, input int cols);
      return data_width + $clog2(rows * cols);
   endfunction

endpackage

// File: rtl/mat_index_counter.sv
// -----------------------------------------------------------------------------
// mat_index_counter
// Linear element index k with its row/column decomposition kept as separate
// counters, so k / COLS and k % COLS never need a divider.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   i_clear  : synchronous clear to element 0
//   i_enable : advance one element (wraps to 0 after the last)
//   o_k      : linear index
//   o_r      : row index
//   o_c      : column index
//   o_last   : o_k is the final element N-1
// -----------------------------------------------------------------------------
module mat_index_counter
   import mat_dma_pkg::*;
#(
   parameter int  ROWS = 4,
   parameter int  COLS = 4,
   localparam int N    = mat_n(ROWS, COLS),
   localparam int KW   = mat_ram_aw(ROWS, COLS),
   localparam int RW   = clog2_min1(ROWS),
   localparam int CW   = clog2_min1(COLS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clear,
   input  logic          i_enable,
   output logic [KW-1:0] o_k,
   output logic [RW-1:0] o_r,
   output logic [CW-1:0] o_c,
   output logic          o_last
);

   logic [KW-1:0] r_k;
   logic [RW-1:0] r_r;
   logic [CW-1:0] r_c;
   logic          w_col_wrap;

   assign w_col_wrap = (r_c == CW'(COLS - 1));
   assign o_last     = (r_k == KW'(N - 1));

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_k <= '0;
         r_r <= '0;
         r_c <= '0;
      end else if (i_enable) begin
         if (o_last) begin
            r_k <= '0;
            r_r <= '0;
            r_c <= '0;
         end else begin
            r_k <= r_k + KW'(1);
            if (w_col_wrap) begin
               r_c <= '0;
               r_r <= r_r + RW'(1);
            end else begin
               r_c <= r_c + CW'(1);
            end
         end
      end
   end

   assign o_k = r_k;
   assign o_r = r_r;
   assign o_c = r_c;

endmodule

// File: rtl/rom.sv
// -----------------------------------------------------------------------------
// rom
// Synchronous-read coefficient ROM (one cycle read latency). The image
// matches rom_file.mem: word a holds (a + 1) mod ROM_DEPTH, i.e. 01..0F,00
// for the default 16-word ROM. An empty INIT_FILE yields a blank ROM.
// Ports:
//   clk    : clock, rising edge
//   i_addr : word address
//   o_data : registered read data
// -----------------------------------------------------------------------------
module rom #(
   parameter int    DATA_WIDTH = 8,
   parameter int    ROM_DEPTH  = 16,
   parameter string INIT_FILE  = "rom_file.mem",
   localparam int   AW         = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
   input  logic                  clk,
   input  logic [AW-1:0]         i_addr,
   output logic [DATA_WIDTH-1:0] o_data
);

   localparam bit HAS_IMAGE = (INIT_FILE != "");

   function automatic logic [DATA_WIDTH-1:0] image_word(input logic [AW-1:0] addr);
      int value;
      value = (int'(addr) + 1) % ROM_DEPTH;
      return DATA_WIDTH'(value);
   endfunction

   // NOTE: clocked state is always assigned with <= so every flop samples
   // the pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge clk) begin
      o_data <= HAS_IMAGE ? image_word(i_addr) : '0;
   end

endmodule

// File: rtl/simple_dualport_mem.sv
// -----------------------------------------------------------------------------
// simple_dualport_mem
// One write port, one registered read port, same clock.
// Ports:
//   clk     : clock, rising edge
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, one cycle after i_raddr
// -----------------------------------------------------------------------------
module simple_dualport_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AW         = 4
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [AW-1:0]         i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]         i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset so it maps onto block RAM; its contents
   // are always written before they are read.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/mat_dma_loader.sv
// -----------------------------------------------------------------------------
// mat_dma_loader
// One start pulse copies ROWS*COLS words from the ROM window at src_base
// (address wraps modulo ROM_DEPTH) into a staging RAM, then reads the RAM
// back into a registered ROWS x COLS matrix, row-major or transposed
// (transpose only honoured for square matrices). done arrives 2N+3 cycles
// after the accepting edge.
// Optional feature: define MAT_DMA_CHECKSUM_EN to add the checksum port
// (unsigned sum of all captured elements, valid with matrix_valid).
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous, active-high
//   start        : load request, sampled in IDLE only
//   src_base     : first ROM address, latched on accept
//   transpose    : transposed placement, latched on accept
//   busy         : load in progress (cycle after accept through done)
//   done         : single-cycle completion pulse
//   matrix_valid : matrix_data holds a complete load
//   matrix_data  : loaded matrix
//   checksum     : (MAT_DMA_CHECKSUM_EN only) element sum
// -----------------------------------------------------------------------------
module mat_dma_loader
   import mat_dma_pkg::*;
#(
   parameter int    DATA_WIDTH = 8,
   parameter int    ROWS       = 4,
   parameter int    COLS       = 4,
   parameter int    ROM_DEPTH  = 16,
   parameter string INIT_FILE  = "rom_file.mem",
   localparam int   ROM_AW     = clog2_min1(ROM_DEPTH),
   localparam int   N          = mat_n(ROWS, COLS),
   localparam int   RAM_AW     = mat_ram_aw(ROWS, COLS)
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        start,
   input  logic [ROM_AW-1:0]                           src_base,
   input  logic                                        transpose,
   output logic                                        busy,
   output logic                                        done,
   output logic                                        matrix_valid,
   output logic [0:ROWS-1][0:COLS-1][DATA_WIDTH-1:0]   matrix_data
`ifdef MAT_DMA_CHECKSUM_EN
   ,
   output logic [mat_csum_w(DATA_WIDTH, ROWS, COLS)-1:0] checksum
`endif
);

   localparam int RW     = clog2_min1(ROWS);
   localparam int CW     = clog2_min1(COLS);
   localparam bit SQUARE = (ROWS == COLS);

   mat_dma_state_t r_state, w_next_state;

   logic                  w_accept;
   logic                  w_cnt_clear;
   logic                  w_cnt_en;
   logic [RAM_AW-1:0]     w_k;
   logic [RW-1:0]         w_r;
   logic [CW-1:0]         w_c;
   logic                  w_last;

   logic [ROM_AW-1:0]     r_src_base;
   logic                  r_transpose;
   logic [31:0]           w_rom_sum;
   logic [ROM_AW-1:0]     w_rom_addr;
   logic [DATA_WIDTH-1:0] w_rom_data;

   logic                  r_wr_en;
   logic [RAM_AW-1:0]     r_wr_addr;
   logic [DATA_WIDTH-1:0] w_ram_rdata;

   logic                  r_cap_en;
   logic [RW-1:0]         r_cap_row;
   logic [CW-1:0]         r_cap_col;
   logic [RW-1:0]         w_dst_row;
   logic [CW-1:0]         w_dst_col;

   logic [0:ROWS-1][0:COLS-1][DATA_WIDTH-1:0] r_matrix_data;
   logic                  r_matrix_valid;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case can leave a signal unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE: if (start)  w_next_state = ST_COPY;
         ST_COPY: if (w_last) w_next_state = ST_WAIT;
         ST_WAIT:             w_next_state = ST_READ;
         ST_READ: if (w_last) w_next_state = ST_LAST;
         ST_LAST:             w_next_state = ST_DONE;
         ST_DONE:             w_next_state = ST_IDLE;
         default:             w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      w_accept    = 1'b0;
      w_cnt_clear = 1'b0;
      w_cnt_en    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_accept    = start;
            w_cnt_clear = start;
         end
         ST_COPY: begin
            busy     = 1'b1;
            w_cnt_en = 1'b1;
         end
         ST_WAIT: begin
            busy        = 1'b1;
            w_cnt_clear = 1'b1;
         end
         ST_READ: begin
            busy     = 1'b1;
            w_cnt_en = 1'b1;
         end
         ST_LAST: busy = 1'b1;
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------- index counter
   mat_index_counter #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_index (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_cnt_clear),
      .i_enable (w_cnt_en),
      .o_k      (w_k),
      .o_r      (w_r),
      .o_c      (w_c),
      .o_last   (w_last)
   );

   // --------------------------------------------------------- request latch
   always_ff @(posedge clk) begin
      if (reset) begin
         r_src_base  <= '0;
         r_transpose <= 1'b0;
      end else if (w_accept) begin
         r_src_base  <= src_base;
         r_transpose <= transpose & SQUARE;
      end
   end

   // ------------------------------------------------------------ COPY phase
   // Window addresses wrap silently modulo ROM_DEPTH.
   assign w_rom_sum  = 32'(r_src_base) + 32'(w_k);
   assign w_rom_addr = ROM_AW'(w_rom_sum % 32'(ROM_DEPTH));

   rom #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROM_DEPTH  (ROM_DEPTH),
      .INIT_FILE  (INIT_FILE)
   ) u_rom (
      .clk    (clk),
      .i_addr (w_rom_addr),
      .o_data (w_rom_data)
   );

   // ROM data lags its address by one cycle, so the write side is the
   // COPY-phase index delayed by one; the final write lands in WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_en  <= 1'b0;
         r_cap_en <= 1'b0;
      end else begin
         r_wr_en  <= (r_state == ST_COPY);
         r_cap_en <= (r_state == ST_READ);
      end
   end

   always_ff @(posedge clk) begin
      r_wr_addr <= w_k;
      r_cap_row <= w_r;
      r_cap_col <= w_c;
   end

   simple_dualport_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (N),
      .AW         (RAM_AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (r_wr_en),
      .i_waddr (r_wr_addr),
      .i_wdata (w_rom_data),
      .i_raddr (w_k),
      .o_rdata (w_ram_rdata)
   );

   // ------------------------------------------------------------ READ phase
   generate
      if (SQUARE) begin : g_square
         assign w_dst_row = r_transpose ? RW'(r_cap_col) : r_cap_row;
         assign w_dst_col = r_transpose ? CW'(r_cap_row) : r_cap_col;
      end else begin : g_rect
         logic w_unused_transpose;
         assign w_unused_transpose = r_transpose;
         assign w_dst_row = r_cap_row;
         assign w_dst_col = r_cap_col;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_matrix_data <= '0;
      end else if (r_cap_en) begin
         r_matrix_data[w_dst_row][w_dst_col] <= w_ram_rdata;
      end
   end

   // Element N-1 is captured at the end of LAST, so valid rises with done.
   always_ff @(posedge clk) begin
      if (reset || w_accept) begin
         r_matrix_valid <= 1'b0;
      end else if (r_state == ST_LAST) begin
         r_matrix_valid <= 1'b1;
      end
   end

   assign matrix_data  = r_matrix_data;
   assign matrix_valid = r_matrix_valid;

`ifdef MAT_DMA_CHECKSUM_EN
   localparam int CSUM_W = mat_csum_w(DATA_WIDTH, ROWS, COLS);

   logic [CSUM_W-1:0] r_checksum;

   always_ff @(posedge clk) begin
      if (reset || w_accept) begin
         r_checksum <= '0;
      end else if (r_cap_en) begin
         r_checksum <= r_checksum + CSUM_W'(w_ram_rdata);
      end
   end

   assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mat_dma_loader.sv
module tb_mat_dma_loader;

   localparam int DW    = 8;
   localparam int RS    = 4;
   localparam int CS    = 4;
   localparam int DEPTH = 16;
   localparam int NN    = RS * CS;

   typedef logic [0:RS-1][0:CS-1][DW-1:0] mat_t;
   typedef logic [0:1][0:7][DW-1:0]       mat_ns_t;
   typedef struct {
      mat_t        m;
      logic [11:0] cs;
   } exp_t;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       start     = 1'b0;
   logic       start_ns  = 1'b0;
   logic       transpose = 1'b0;
   logic       tr_ns     = 1'b1;
   logic [3:0] src_base  = 4'd0;

   logic       busy, done, matrix_valid;
   mat_t       matrix_data;
   logic       busy_ns, done_ns, valid_ns;
   mat_ns_t    data_ns;
`ifdef MAT_DMA_CHECKSUM_EN
   logic [11:0] checksum, checksum_ns;
`endif

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   mat_dma_loader dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .src_base     (src_base),
      .transpose    (transpose),
      .busy         (busy),
      .done         (done),
      .matrix_valid (matrix_valid),
      .matrix_data  (matrix_data)
`ifdef MAT_DMA_CHECKSUM_EN
      ,
      .checksum     (checksum)
`endif
   );

   mat_dma_loader #(.ROWS(2), .COLS(8)) dut_ns (
      .clk          (clk),
      .reset        (reset),
      .start        (start_ns),
      .src_base     (src_base),
      .transpose    (tr_ns),
      .busy         (busy_ns),
      .done         (done_ns),
      .matrix_valid (valid_ns),
      .matrix_data  (data_ns)
`ifdef MAT_DMA_CHECKSUM_EN
      ,
      .checksum     (checksum_ns)
`endif
   );

   function automatic logic [DW-1:0] rom_model(input int addr);
      return DW'((addr + 1) % DEPTH);
   endfunction

   function automatic exp_t model(input int base, input bit tr);
      exp_t e;
      e.m  = '0;
      e.cs = '0;
      for (int k = 0; k < NN; k++) begin
         logic [DW-1:0] v;
         int r, c;
         v = rom_model((base + k) % DEPTH);
         r = k / CS;
         c = k % CS;
         if (tr) e.m[c][r] = v;
         else    e.m[r][c] = v;
         e.cs = e.cs + 12'(v);
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One load on the 4x4 DUT. poke pulses start at t0+5 and at the DONE
   // cycle with different arguments; reset_at > 0 asserts reset in that cycle.
   task automatic do_load(input logic [3:0] base, input bit tr, input bit poke,
                          input int reset_at, input string tag);
      exp_t e;
      int   done_cnt = 0;
      int   done_at  = -1;
      bit   aborted  = 1'b0;
      if (reset_at == 0) sb_q.push_back(model(int'(base), tr));
      @(negedge clk);
      src_base  = base;
      transpose = tr;
      start     = 1'b1;
      for (int i = 1; i <= 40 && !aborted; i++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = i;
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  check({tag, " matrix"}, matrix_data, e.m);
                  check({tag, " valid_at_done"}, matrix_valid, 1);
`ifdef MAT_DMA_CHECKSUM_EN
                  check({tag, " checksum"}, checksum, e.cs);
`endif
               end else begin
                  check({tag, " unexpected_done"}, 1, 0);
               end
            end
         end
         if (i == 1)  check({tag, " busy_rise"}, busy, 1);
         if (i == 10) check({tag, " valid_low_mid"}, matrix_valid, 0);
         if (i == 36 && reset_at == 0) check({tag, " busy_fall"}, busy, 0);
         if (reset_at != 0 && i == reset_at + 1) begin
            check({tag, " rst_busy"}, busy, 0);
            check({tag, " rst_done"}, done, 0);
            check({tag, " rst_valid"}, matrix_valid, 0);
            check({tag, " rst_matrix"}, matrix_data, '0);
            reset   = 1'b0;
            aborted = 1'b1;
         end
         start = poke && (i == 5 || i == 35);
         if (start) begin
            src_base  = 4'd7;
            transpose = ~tr;
         end
         if (reset_at == i) reset = 1'b1;
      end
      start = 1'b0;
      if (!aborted) begin
         check({tag, " done_latency"}, done_at, 35);
         check({tag, " done_count"}, done_cnt, 1);
      end
   endtask

   task automatic do_load_ns();
      mat_ns_t exp_m;
      int      done_at = -1;
      exp_m = '0;
      for (int k = 0; k < 16; k++) exp_m[k / 8][k % 8] = rom_model(k);
      @(negedge clk);
      src_base = 4'd0;
      start_ns = 1'b1;
      for (int i = 1; i <= 60 && done_at < 0; i++) begin
         @(negedge clk);
         start_ns = 1'b0;
         if (done_ns) begin
            done_at = i;
            check("ns matrix_rowmajor", data_ns, exp_m);
            check("ns valid", valid_ns, 1);
`ifdef MAT_DMA_CHECKSUM_EN
            check("ns checksum", checksum_ns, 12'h078);
`endif
         end
      end
      check("ns done_latency", done_at, 35);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset valid", matrix_valid, 0);
      check("reset matrix", matrix_data, '0);
`ifdef MAT_DMA_CHECKSUM_EN
      check("reset checksum", checksum, 0);
`endif
      reset = 1'b0;
      @(negedge clk);
      check("idle busy", busy, 0);

      do_load(4'd0, 1'b0, 1'b0, 0, "rowmajor");
      check("rowmajor row0", matrix_data[0], 32'h01020304);
      check("rowmajor row3", matrix_data[3], 32'h0D0E0F00);
`ifdef MAT_DMA_CHECKSUM_EN
      check("rowmajor checksum_78", checksum, 12'h078);
`endif

      do_load(4'd0, 1'b1, 1'b0, 0, "transpose");
      check("transpose m30", matrix_data[3][0], 8'h04);
      check("transpose m03", matrix_data[0][3], 8'h0D);
      check("transpose m10", matrix_data[1][0], 8'h02);

      do_load(4'd14, 1'b0, 1'b0, 0, "wrap");
      check("wrap m00", matrix_data[0][0], 8'h0F);
      check("wrap m01", matrix_data[0][1], 8'h00);
      check("wrap m33", matrix_data[3][3], 8'h0E);

      do_load(4'd3, 1'b1, 1'b1, 0, "poke");
      repeat (3) @(negedge clk);
      check("poke stays_idle", busy, 0);

      do_load(4'd5, 1'b0, 1'b0, 25, "reset_mid");
      do_load(4'd9, 1'b1, 1'b0, 0, "after_reset");

      do_load_ns();

      check("scoreboard drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mat_dma_loader.md
# mat_dma_loader

Parametrised ROM-to-matrix loader. One `start` pulse copies `ROWS*COLS` elements from a ROM window beginning at `src_base` into an internal dual-port RAM. It then reads the RAM back into a registered `ROWS x COLS` matrix output, in row-major or transposed order. It sits between the coefficient ROM and the matrix compute units and replaces ad-hoc ROM/DMA/RAM glue with a single handshaked block that has a defined latency.

## Interface
Parameters:
- `DATA_WIDTH`, 8: element width in bits.
- `ROWS`, 4: matrix rows.
- `COLS`, 4: matrix columns.
- `ROM_DEPTH`, 16: ROM words. `ROM_AW = $clog2(ROM_DEPTH)`.
- `INIT_FILE`, "rom_file.mem": ROM init file, passed to the `rom` instance.
- Derived: `N = ROWS*COLS`; `RAM_AW = $clog2(N)`.

Ports (reset is synchronous and active-high; the clock is `clk`):
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request pulse, sampled in IDLE only.
- `src_base`, input, `ROM_AW`: first ROM address, latched on accept.
- `transpose`, input, 1: latched on accept. Honoured only when `ROWS==COLS`; otherwise forced to 0.
- `busy`, output, 1: high from the cycle after accept until `done`, inclusive.
- `done`, output, 1: single-cycle completion pulse.
- `matrix_valid`, output, 1: matrix holds a complete load.
- `matrix_data`, output, `[0:ROWS-1][0:COLS-1]` x `DATA_WIDTH`: loaded matrix.

## Operation
States: IDLE, COPY, WAIT, READ, LAST, DONE.

- **IDLE**
  - On `start`: latch `src_base` and `transpose`, clear `k`, clear `matrix_valid`, go to COPY.
- **COPY**, N cycles
  - ROM address = `(src_base + k) mod ROM_DEPTH`. The address wraps silently past `ROM_DEPTH-1`.
  - The ROM word returns one cycle later and is written to RAM address `k-1`.
  - After `k = N-1` is issued, go to WAIT.
- **WAIT**, 1 cycle
  - The last RAM write (address `N-1`) completes.
  - The index counter resets.
- **READ**, N cycles
  - RAM read address = `k`. The data returns one cycle later.
  - The returned element `k` is written to `matrix_data[r][c]`, where `r = k / COLS` and `c = k % COLS`.
  - If transpose is in effect, it is written to `matrix_data[c][r]` instead.
- **LAST**, 1 cycle
  - Captures element `N-1`.
- **DONE**, 1 cycle
  - `done=1`, `matrix_valid` set, then return to IDLE.

Rules:
- `start` while not in IDLE (including DONE) is ignored. It is not queued.
- `matrix_data` holds its value between loads. A new accepted `start` overwrites entries progressively. `matrix_valid` stays low until the new `done`.
- Indices `r`/`c` come from a row/column counter. `c` wraps at `COLS-1`, and `r` increments on that wrap. Division is never synthesised.
- `reset` at any time has priority:
  - State returns to IDLE and `k` is cleared.
  - Every `matrix_data` element, `busy`, `done` and `matrix_valid` go to 0.
  - RAM contents are don't-care.

## Timing
- Reset values: `busy=0`, `done=0`, `matrix_valid=0`, `matrix_data` all 0.
- `start` is sampled high at edge `t0`. `busy` rises at `t0+1`. `done` is high for the cycle at `t0 + 2N + 3`. `busy` falls one cycle after that.
- The default 4x4 completes with `done` at `t0+35`.
- ROM read latency is 1 cycle. RAM read latency is 1 cycle, with write-before-read separation guaranteed by WAIT.
- One element moves per cycle in each phase. There are no stall cycles and no backpressure.

## Configuration
- `MAT_DMA_CHECKSUM_EN` defined:
  - Adds output `checksum`, width `DATA_WIDTH + $clog2(N)`, unsigned sum of all N elements captured during READ/LAST.
  - `checksum` is cleared on accept and on reset, and is valid with `matrix_valid`.
- Undefined: the port and the accumulator are absent. All other behaviour is identical.

## Structure
- Package `mat_dma_pkg`:
  - State enum `mat_dma_state_t`.
  - The localparam helpers for `N`, `RAM_AW` and checksum width.
- The existing `rom` and `simple_dualport_mem` blocks are instantiated unchanged.
- One new sub-module, `mat_index_counter`: parametrised `ROWS`/`COLS` counter with clear and enable. It outputs `k`, `r`, `c` and `last`.

## Test plan
- **Default 4x4 load:** `INIT_FILE` = 01..0F,00; `start` with `src_base=0`, `transpose=0` -> `done` at `t0+35`; row 0 = 01 02 03 04; row 3 = 0D 0E 0F 00; `matrix_valid=1`.
- **Transposed load:** same ROM, `transpose=1` -> column 0 = 01 02 03 04; `matrix_data[3][0]=04`; `matrix_data[0][3]=0D`.
- **Address wrap:** `src_base=14` -> element order 0F, 00, 01 .. 0E; `matrix_data[0][0]=0F`; `matrix_data[3][3]=0E`.
- **Start while busy:** `start` pulsed at `t0+5` and at the DONE cycle -> ignored; exactly one `done`; `busy` low after `t0+36`.
- **Reset mid-READ:** assert `reset` at `t0+25` -> next cycle all outputs 0, state IDLE. A fresh `start` then completes normally in 35 cycles.
- **Checksum (`MAT_DMA_CHECKSUM_EN`):** default ROM -> `checksum = 0x78` at `done`. With `ROWS=2`, `COLS=8` non-square and `transpose=1` -> row-major result, `checksum` unchanged.
